stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Tick-consuming timekeeper for the stopwatch datapath. It receives the single-cycle enable pulse produced by the clock divider and accumulates elapsed time as six BCD digits (mm:ss.cc). A start/stop/lap/clear control FSM gates the count. It sits between the divider/button front end and the seven-segment display driver.

## Interface
- WRAP, 1: 1 = roll over 59:59.99 -> 00:00.00 and keep running; 0 = saturate at 59:59.99 and pause.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset; dominates every other input.
- tick  in  1  single-cycle 100 Hz enable pulse from the divider; one tick = 0.01 s.
- startStop  in  1  single-cycle debounced press pulse.
- lap  in  1  single-cycle debounced press pulse.
- clear  in  1  single-cycle debounced press pulse.
- timeOut  out  24  displayed time {mm tens, mm units, ss tens, ss units, cc tens, cc units}, 4-bit BCD each, MSB first.
- running  out  1  high in RUN and LAP.
- lapActive  out  1  high in LAP (display frozen).
- overflow  out  1  sticky; set when the count passes 59:59.99.

## Operation
- Registers: live count (24-bit BCD), lap latch (24-bit BCD), state, overflow.
- States: IDLE (count zero, stopped), RUN, LAP (counting, display frozen), PAUSE (stopped, count held).
- Transitions:
  - IDLE: startStop -> RUN.
  - RUN: startStop -> PAUSE; lap -> LAP, latch <= next count.
  - LAP: lap -> RUN; startStop -> PAUSE (freeze released).
  - PAUSE: startStop -> RUN; clear -> IDLE, count <= 0, overflow <= 0.
  - Otherwise stay.
- Unlisted pulses are ignored: clear in RUN/LAP/IDLE, lap in IDLE/PAUSE.
- Simultaneous pulses: priority startStop > lap > clear. Only the winner acts; the others are dropped, not queued.
- Counting: the count increments on tick only when the current (pre-edge) state is RUN or LAP.
  - tick with startStop in RUN: the tick is counted, then the FSM pauses.
  - tick with startStop in PAUSE: the tick is not counted.
- Digit limits: cc units 0-9, cc tens 0-9, ss units 0-9, ss tens 0-5, mm units 0-9, mm tens 0-5. Carries ripple in one cycle. No digit ever holds a non-BCD value.
- Terminal count 59:59.99 plus a tick:
  - WRAP=1: count <= 00:00.00, overflow <= 1, state unchanged.
  - WRAP=0: count holds 59:59.99, overflow <= 1, state -> PAUSE. Later startStop -> RUN, and each further tick keeps it at 59:59.99 and re-pauses.
- timeOut = lap latch in LAP, otherwise live count.
- running = (state is RUN or LAP); lapActive = (state is LAP).
- Lap latch keeps its last value outside LAP. It is zeroed only by rst.

## Timing
- Reset values: timeOut 0x000000, running 0, lapActive 0, overflow 0, state IDLE, count and latch 0.
- rst asserted mid-run zeroes everything on that edge; a coincident tick or press is lost.
- Latency: an input sampled at edge N is reflected on all outputs directly after edge N. Outputs are decoded from registers only, with no combinational input-to-output path.
- A lap press coincident with a tick latches the incremented value.
- Max count rate: one increment per clk, so back-to-back tick is legal and each one is counted.
- Inputs held high for several cycles act once per cycle. Edge detection is upstream's job.

## Test plan
- Reset, startStop, then 100 ticks -> timeOut 0x000100 (00:01.00), running 1. rst mid-stream -> all outputs 0 next cycle.
- Carry chain: preload by 5999 ticks to 00:59.99, one more tick -> 0x010000. Check every intermediate digit stays ≤9 (tens of ss ≤5).
- Lap: at 00:00.37 pulse lap -> timeOut frozen 0x000037 and lapActive 1 while 20 more ticks pass. Lap again -> timeOut 0x000057, lapActive 0.
- Pause/clear: startStop at 00:00.10 with a coincident tick -> PAUSE showing 0x000011. Ticks ignored. lap and clear together -> lap dropped, clear wins -> 0x000000, IDLE.
- Overflow WRAP=1: run to 59:59.99, one tick -> 0x000000, overflow 1, running 1. clear after pause -> overflow 0.
- Overflow WRAP=0: at 59:59.99 one tick -> timeOut 0x595999, overflow 1, running 0. Simultaneous startStop+lap+clear in PAUSE -> RUN only.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: six-digit BCD elapsed-time counter (mm:ss.cc) driven by a
// 100 Hz tick, gated by a start/stop/lap/clear control FSM.
module stopwatch_core #(
  parameter bit WRAP = 1'b1  // 1: roll over at 59:59.99, 0: saturate and pause
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        startStop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] timeOut,
  output logic        running,
  output logic        lapActive,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Highest legal value of each digit, LSB digit first: cc units .. mm tens.
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  state_t      state_q, state_d;
  logic [23:0] count_q, count_d;
  logic [23:0] latch_q, latch_d;
  logic        overflow_q, overflow_d;

  logic [6:0]  carry;
  logic [23:0] count_inc;
  logic        counting;
  logic        terminal;
  logic [23:0] count_tick;

  // Ripple-carry BCD incrementer; carry[6] set means the count is 59:59.99.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      logic at_max;
      assign at_max         = (count_q[gi*4 +: 4] == DIGIT_MAX[gi*4 +: 4]);
      assign carry[gi+1]    = carry[gi] & at_max;
      assign count_inc[gi*4 +: 4] = !carry[gi] ? count_q[gi*4 +: 4] :
                                    (at_max ? 4'd0 : count_q[gi*4 +: 4] + 4'd1);
    end
  endgenerate

  assign terminal = carry[6];
  assign counting = tick && ((state_q == S_RUN) || (state_q == S_LAP));

  // Next-state, count, lap latch and overflow logic.
  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    overflow_d = overflow_q;
    count_tick = count_q;

    // Tick is applied first so a coincident lap latches the new value.
    if (counting) begin
      if (terminal) begin
        overflow_d = 1'b1;
        count_tick = WRAP ? 24'h000000 : count_q;
      end else begin
        count_tick = count_inc;
      end
    end
    count_d = count_tick;

    // Button priority startStop > lap > clear; pulses not valid in a state fall through.
    case (state_q)
      S_IDLE: begin
        if (startStop) state_d = S_RUN;
      end
      S_RUN: begin
        if (startStop) begin
          state_d = S_PAUSE;
        end else if (lap) begin
          state_d = S_LAP;
          latch_d = count_tick;
        end
      end
      S_LAP: begin
        if (startStop) begin
          state_d = S_PAUSE;
        end else if (lap) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (startStop) begin
          state_d = S_RUN;
        end else if (clear) begin
          state_d    = S_IDLE;
          count_d    = 24'h000000;
          overflow_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating mode stops the watch when the terminal count is hit.
    if (!WRAP && counting && terminal) state_d = S_PAUSE;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 24'h000000;
      latch_q    <= 24'h000000;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      latch_q    <= latch_d;
      overflow_q <= overflow_d;
    end
  end

  assign timeOut   = (state_q == S_LAP) ? latch_q : count_q;
  assign running   = (state_q == S_RUN) || (state_q == S_LAP);
  assign lapActive = (state_q == S_LAP);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: a wrapping and a saturating instance share
// stimulus; an integer-centisecond model feeds a scoreboard queue.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst, tick, startStop, lap, clear;
  logic [23:0] time_w, time_s;
  logic        run_w, run_s, lap_w, lap_s, ovf_w, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .tick(tick), .startStop(startStop), .lap(lap), .clear(clear),
    .timeOut(time_w), .running(run_w), .lapActive(lap_w), .overflow(ovf_w)
  );

  stopwatch_core #(.WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .tick(tick), .startStop(startStop), .lap(lap), .clear(clear),
    .timeOut(time_s), .running(run_s), .lapActive(lap_s), .overflow(ovf_s)
  );

  typedef struct {
    logic [23:0] t;
    logic        r;
    logic        l;
    logic        o;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  // Model: state 0 IDLE, 1 RUN, 2 LAP, 3 PAUSE; time in centiseconds.
  int m_st[2];
  int m_cs[2];
  int m_latch[2];
  bit m_ovf[2];

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [23:0] t);
    return (t[23:20] <= 4'd5) && (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) &&
           (t[11:8] <= 4'd9) && (t[7:4] <= 4'd9) && (t[3:0] <= 4'd9);
  endfunction

  task automatic model(input int w, input bit r, ss, lp, cl, tk);
    bit wrap, cnt_en, term;
    wrap = (w == 0);
    if (r) begin
      m_st[w] = 0; m_cs[w] = 0; m_latch[w] = 0; m_ovf[w] = 0;
      return;
    end
    cnt_en = tk && (m_st[w] == 1 || m_st[w] == 2);
    term   = 1'b0;
    if (cnt_en) begin
      if (m_cs[w] == 359999) begin
        term = 1'b1;
        m_ovf[w] = 1'b1;
        if (wrap) m_cs[w] = 0;
      end else begin
        m_cs[w] = m_cs[w] + 1;
      end
    end
    case (m_st[w])
      0: if (ss) m_st[w] = 1;
      1: if (ss) m_st[w] = 3;
         else if (lp) begin m_st[w] = 2; m_latch[w] = m_cs[w]; end
      2: if (ss) m_st[w] = 3;
         else if (lp) m_st[w] = 1;
      default: if (ss) m_st[w] = 1;
               else if (cl) begin m_st[w] = 0; m_cs[w] = 0; m_ovf[w] = 1'b0; end
    endcase
    if (term && !wrap) m_st[w] = 3;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, push model results, then pop and compare.
  task automatic step(input string tag, input bit r, ss, lp, cl, tk);
    exp_t e;
    exp_t g;
    string tg;
    @(negedge clk);
    rst = r; startStop = ss; lap = lp; clear = cl; tick = tk;
    for (int w = 0; w < 2; w++) begin
      model(w, r, ss, lp, cl, tk);
      e.t = (m_st[w] == 2) ? to_bcd(m_latch[w]) : to_bcd(m_cs[w]);
      e.r = (m_st[w] == 1) || (m_st[w] == 2);
      e.l = (m_st[w] == 2);
      e.o = m_ovf[w];
      sb_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; startStop = 1'b0; lap = 1'b0; clear = 1'b0; tick = 1'b0;
    g = sb_q.pop_front(); tg = tag_q.pop_front();
    chk({tg, " wrap.timeOut"}, time_w, g.t);
    chk({tg, " wrap.running"}, 24'(run_w), 24'(g.r));
    chk({tg, " wrap.lapActive"}, 24'(lap_w), 24'(g.l));
    chk({tg, " wrap.overflow"}, 24'(ovf_w), 24'(g.o));
    chk({tg, " wrap.bcd_ok"}, 24'(bcd_ok(time_w)), 24'd1);
    g = sb_q.pop_front(); tg = tag_q.pop_front();
    chk({tg, " sat.timeOut"}, time_s, g.t);
    chk({tg, " sat.running"}, 24'(run_s), 24'(g.r));
    chk({tg, " sat.lapActive"}, 24'(lap_s), 24'(g.l));
    chk({tg, " sat.overflow"}, 24'(ovf_s), 24'(g.o));
    chk({tg, " sat.bcd_ok"}, 24'(bcd_ok(time_s)), 24'd1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; startStop = 1'b0; lap = 1'b0; clear = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_st[w] = 0; m_cs[w] = 0; m_latch[w] = 0; m_ovf[w] = 1'b0;
    end

    // Reset state, start, 100 ticks -> 00:01.00
    step("reset", 1, 0, 0, 0, 0);
    step("reset2", 1, 0, 0, 0, 0);
    step("start", 0, 1, 0, 0, 0);
    repeat (100) step("run100", 0, 0, 0, 0, 1);
    step("idle_cycle", 0, 0, 0, 0, 0);
    // Reset mid-run with a coincident tick and press
    step("rst_mid", 1, 1, 0, 0, 1);

    // Carry chain to 00:59.99 then 01:00.00
    step("start2", 0, 1, 0, 0, 0);
    repeat (5999) step("carry", 0, 0, 0, 0, 1);
    step("carry_min", 0, 0, 0, 0, 1);

    // Lap freeze and release
    step("rst_lap", 1, 0, 0, 0, 0);
    step("start3", 0, 1, 0, 0, 0);
    repeat (37) step("to37", 0, 0, 0, 0, 1);
    step("lap_on", 0, 0, 1, 0, 0);
    repeat (20) step("frozen", 0, 0, 0, 0, 1);
    step("lap_off", 0, 0, 1, 0, 0);
    step("lap_tick", 0, 0, 1, 0, 1);
    step("lap_tick_off", 0, 0, 1, 0, 1);
    step("lap_ss", 0, 0, 1, 0, 0);
    step("lap_to_pause", 0, 1, 0, 0, 1);

    // Pause with coincident tick, ignored ticks, lap+clear
    step("rst_pause", 1, 0, 0, 0, 0);
    step("start4", 0, 1, 0, 0, 0);
    step("clear_in_run", 0, 0, 0, 1, 0);
    repeat (10) step("to10", 0, 0, 0, 0, 1);
    step("stop_tick", 0, 1, 0, 0, 1);
    repeat (3) step("paused_tick", 0, 0, 0, 0, 1);
    step("lap_clear", 0, 0, 1, 1, 0);
    step("idle_tick", 0, 0, 0, 0, 1);

    // Terminal count: preload both instances to 59:59.98 while running
    step("rst_ovf", 1, 0, 0, 0, 0);
    step("start5", 0, 1, 0, 0, 0);
    step("tick1", 0, 0, 0, 0, 1);
    @(negedge clk);
    force dut_w.count_q = 24'h595998;
    force dut_s.count_q = 24'h595998;
    #1;
    release dut_w.count_q;
    release dut_s.count_q;
    m_cs[0] = 359998;
    m_cs[1] = 359998;
    step("to_term", 0, 0, 0, 0, 1);
    step("term_tick", 0, 0, 0, 0, 1);
    step("ss_after", 0, 1, 0, 0, 0);
    step("clear_after", 0, 0, 0, 1, 0);
    step("sat_retick", 0, 0, 0, 0, 1);
    step("all_three", 0, 1, 1, 1, 0);
    step("tick_after", 0, 0, 0, 0, 1);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
